// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Instruction-fetch controller. It is the only driver of the instruction
//   memory address. It steps the 8-bit program counter through a 256 x 16-bit
//   combinational instruction memory.
//
//   Fetched words go to decode over a valid/ready handshake. Decode can
//   redirect the PC with a jump. A halt opcode stops fetching until the next
//   start pulse.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   start        in   1   one-cycle pulse, begins fetching from IDLE or HALT
//   mem_addr     out  8   instruction memory address (always the current pc)
//   mem_instr    in  16   instruction memory read data (combinational)
//   instr_out    out 16   registered instruction presented to decode
//   instr_valid  out  1   instr_out holds a valid instruction
//   instr_ready  in   1   decode accepts instr_out this cycle
//   jump_valid   in   1   redirect request from decode
//   jump_target  in   8   redirect address
//   busy         out  1   fetching or issuing
//   halted       out  1   stopped on a halt opcode
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [7:0]  RESET_ADDR  = 8'd0,
    parameter logic [3:0]  HALT_OPCODE = 4'b1110,
    parameter logic [15:0] NOP_WORD    = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_instr,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump_valid,
    input  logic [7:0]  jump_target,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic        is_halt_word;

    assign accept       = valid_q & instr_ready;
    assign is_halt_word = (instr_q[15:12] == HALT_OPCODE);

    // Next-state logic. Every register holds its value unless a transition
    // below overrides it. That makes the ISSUE stall case (ready low) fall
    // out of the defaults.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (jump_valid) begin
                    pc_d = jump_target;
                end else begin
                    instr_d = mem_instr;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 8'd1;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (jump_valid) begin
                    // The presented word is on the wrong path. Drop it even
                    // if decode is accepting it in this same cycle.
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    pc_d    = jump_target;
                    state_d = FETCH;
                end else if (accept && is_halt_word) begin
                    // pc already points past the halt word, so a later
                    // start resumes with the following instruction.
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                    state_d = HALT;
                end else if (accept) begin
                    instr_d = mem_instr;
                    pc_d    = pc_q + 8'd1;
                end
            end

            HALT: begin
                if (start) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_ADDR;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign mem_addr    = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q == FETCH) || (state_q == ISSUE);
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A behavioural instruction memory
// is modelled as an array. Outputs are compared at three levels:
//   - a table of directed vectors,
//   - hand-written corner-case sequences (backpressure, jump, wrap,
//     asynchronous reset),
//   - randomized traffic checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  mem_addr;
    logic [15:0] mem_instr;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump_valid;
    logic [7:0]  jump_target;
    logic        busy;
    logic        halted;

    logic [15:0] mem [256];

    int checks;
    int errors;

    // Reference-model state, kept at the level of "what decode sees":
    //   running  - the sequencer is working (busy)
    //   has_word - a word is held for decode
    logic        m_running;
    logic        m_halted;
    logic        m_has_word;
    logic [15:0] m_word;
    logic [7:0]  m_pc;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_instr   (mem_instr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .busy        (busy),
        .halted      (halted)
    );

    assign mem_instr = mem[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        start;
        logic        ready;
        logic        jv;
        logic [7:0]  jt;
        logic [15:0] exp_instr;
        logic        exp_valid;
        logic [7:0]  exp_addr;
        logic        exp_busy;
        logic        exp_halted;
    } vec_t;

    vec_t vecs [10];

    task automatic checkField(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] e_instr,
                               input logic e_valid, input logic [7:0] e_addr,
                               input logic e_busy, input logic e_halted);
        checkField({tag, ".instr_out"},   instr_out,          e_instr);
        checkField({tag, ".instr_valid"}, {15'd0, instr_valid}, {15'd0, e_valid});
        checkField({tag, ".mem_addr"},    {8'd0, mem_addr},   {8'd0, e_addr});
        checkField({tag, ".busy"},        {15'd0, busy},      {15'd0, e_busy});
        checkField({tag, ".halted"},      {15'd0, halted},    {15'd0, e_halted});
    endtask

    // Drive inputs on the falling edge, then wait past the rising edge so
    // the outputs can be sampled away from the active edge.
    task automatic applyStimulus(input logic s, input logic r, input logic jv,
                                 input logic [7:0] jt);
        @(negedge clk);
        start       = s;
        instr_ready = r;
        jump_valid  = jv;
        jump_target = jt;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst         = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        jump_valid  = 1'b0;
        jump_target = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic modelReset();
        m_running  = 1'b0;
        m_halted   = 1'b0;
        m_has_word = 1'b0;
        m_word     = 16'hF000;
        m_pc       = 8'h00;
    endtask

    // One clock of the reference model, using the inputs present at the
    // edge.
    task automatic modelStep();
        if (!m_running) begin
            if (start) begin
                m_running = 1'b1;
                m_halted  = 1'b0;
            end
        end else if (!m_has_word) begin
            if (jump_valid) begin
                m_pc = jump_target;
            end else begin
                m_word     = mem[m_pc];
                m_has_word = 1'b1;
                m_pc       = m_pc + 8'd1;
            end
        end else begin
            if (jump_valid) begin
                m_has_word = 1'b0;
                m_word     = 16'hF000;
                m_pc       = jump_target;
            end else if (instr_ready) begin
                if (m_word[15:12] == 4'hE) begin
                    m_has_word = 1'b0;
                    m_word     = 16'hF000;
                    m_running  = 1'b0;
                    m_halted   = 1'b1;
                end else begin
                    m_word = mem[m_pc];
                    m_pc   = m_pc + 8'd1;
                end
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        jump_valid  = 1'b0;
        jump_target = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'hF000; mem[1] = 16'h0102; mem[2] = 16'h0103;
        mem[3] = 16'hF000; mem[4] = 16'h0104; mem[5] = 16'hE000;
        mem[6] = 16'h0106; mem[7] = 16'h0107; mem[10] = 16'h7510;
        mem[255] = 16'hF000;

        // Streaming with ready held high, a halt, then a resume.
        //         start ready jv jt     instr     v  addr   busy halt
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 16'hF000, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hF000, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0102, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0103, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hF000, 1'b1, 8'h04, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0104, 1'b1, 8'h05, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hE000, 1'b1, 8'h06, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hF000, 1'b0, 8'h06, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h40, 16'hF000, 1'b0, 8'h06, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0106, 1'b1, 8'h07, 1'b1, 1'b0};

        #1;
        checkOutput("reset", 16'hF000, 1'b0, 8'h00, 1'b0, 1'b0);
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
        checkOutput("idle_ignore", 16'hF000, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].start, vecs[i].ready, vecs[i].jv, vecs[i].jt);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_valid,
                        vecs[i].exp_addr, vecs[i].exp_busy, vecs[i].exp_halted);
        end

        // Backpressure: 0102 must stay presented while ready is low.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("bp_first", 16'hF000, 1'b1, 8'h01, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("bp_present", 16'h0102, 1'b1, 8'h02, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("bp_hold%0d", i), 16'h0102, 1'b1, 8'h02, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("bp_release", 16'h0103, 1'b1, 8'h03, 1'b1, 1'b0);

        // Jump with ready high: the presented word is discarded.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h0A);
        checkOutput("jump_bubble", 16'hF000, 1'b0, 8'h0A, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("jump_target", 16'h7510, 1'b1, 8'h0B, 1'b1, 1'b0);

        // PC wrap from FF to 00.
        @(negedge clk);
        mem[0] = 16'h0102;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
        checkOutput("wrap_jump", 16'hF000, 1'b0, 8'hFF, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("wrap_ff", 16'hF000, 1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("wrap_00", 16'h0102, 1'b1, 8'h01, 1'b1, 1'b0);

        // Asynchronous reset mid-ISSUE with ready low, checked before the
        // next clock edge.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("pre_areset", 16'h0102, 1'b1, 8'h01, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("areset", 16'hF000, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput($sformatf("post_reset%0d", i), 16'hF000, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        doReset();
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) mem[$urandom_range(0, 255)] = 16'($urandom);
            start       = ($urandom_range(0, 3) == 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            jump_valid  = ($urandom_range(0, 7) == 0);
            jump_target = 8'($urandom);
            @(posedge clk);
            modelStep();
            #1;
            checkOutput($sformatf("rand%0d", cyc), m_has_word ? m_word : 16'hF000,
                        m_has_word, m_pc, m_running, m_halted);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
